vga_sync_decoder: RTL and testbench

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

---
 rtl/vga_timing_pkg.sv | 36 +++
 rtl/sync_edge_det.sv | 27 ++
 rtl/vga_sync_decoder.sv | 179 +++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and the sync-decoder state encoding.
// Used by vga_sync_decoder and by vga_display.
package vga_timing_pkg;

  // Horizontal timing in pixel clocks.
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_TOTAL   = VGA_H_SYNC + VGA_H_BACK + VGA_H_VISIBLE + VGA_H_FRONT;
  localparam int VGA_H_START   = VGA_H_SYNC + VGA_H_BACK;

  // Vertical timing in lines.
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;
  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_TOTAL   = VGA_V_SYNC + VGA_V_BACK + VGA_V_VISIBLE + VGA_V_FRONT;
  localparam int VGA_V_START   = VGA_V_SYNC + VGA_V_BACK;

  // Lock acquisition states of the sync decoder.
  typedef enum logic [1:0] {
    HUNT,
    HLINE,
    VWAIT,
    LOCKED
  } sync_state_e;

  // True when first <= count < last_excl (bounds one bit wider than count).
  function automatic logic in_window(input logic [9:0]  count,
                                     input logic [10:0] first,
                                     input logic [10:0] last_excl);
    return ({1'b0, count} >= first) && ({1'b0, count} < last_excl);
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Registers one active-low sync input and flags its falling edge.
// fall is high in the cycle where the delayed copy is 1 and the live input is 0.
module sync_edge_det (
  input  logic clk25,
  input  logic rst,
  input  logic sync_in,
  output logic fall
);

  logic sync_q;
  logic sync_d;

  // Next value of the delayed sync copy.
  always_comb begin
    sync_d = sync_in;
  end

  // Delay register; idles high so a low input right after reset reads as an edge.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk25) begin
    if (rst) sync_q <= 1'b1;
    else     sync_q <= sync_d;
  end

  assign fall = sync_q & ~sync_in;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers pixel/line position from incoming hsync/vsync, tracks timing lock
// and flags timing errors while locked.
// Optional feature: define VGA_SYNC_DECODER_ERRCNT_EN to add a saturating
// err_count[7:0] output counting err pulses.
module vga_sync_decoder
  import vga_timing_pkg::*;
#(
  parameter int H_TOTAL   = VGA_H_TOTAL,
  parameter int H_START   = VGA_H_START,
  parameter int H_VISIBLE = VGA_H_VISIBLE,
  parameter int V_TOTAL   = VGA_V_TOTAL,
  parameter int V_START   = VGA_V_START,
  parameter int V_VISIBLE = VGA_V_VISIBLE
) (
  input  logic       clk25,
  input  logic       rst,
  input  logic       hsync,
  input  logic       vsync,
  output logic [9:0] xpos,
  output logic [9:0] ypos,
  output logic       active,
  output logic       locked,
  output logic       frame_start,
  output logic       err
`ifdef VGA_SYNC_DECODER_ERRCNT_EN
  ,
  output logic [7:0] err_count
`endif
);

  localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0]  CNT_MAX = 10'h3FF;
  localparam logic [9:0]  H_OFF   = 10'(H_START);
  localparam logic [9:0]  V_OFF   = 10'(V_START);
  localparam logic [10:0] H_BEG   = 11'(H_START);
  localparam logic [10:0] H_END   = 11'(H_START + H_VISIBLE);
  localparam logic [10:0] V_BEG   = 11'(V_START);
  localparam logic [10:0] V_END   = 11'(V_START + V_VISIBLE);

  logic        hs_fall, vs_fall;
  logic        vpend_eff, line_end, lock_err;
  sync_state_e state_q, state_d;
  logic [9:0]  hcount_q, hcount_d;
  logic [9:0]  vcount_q, vcount_d;
  logic        vpend_q, vpend_d;
  logic        active_q, active_d;
  logic [9:0]  xpos_q, xpos_d;
  logic [9:0]  ypos_q, ypos_d;
  logic        frame_start_q, frame_start_d;
  logic        err_q, err_d;

  sync_edge_det u_hs_edge (
    .clk25   (clk25),
    .rst     (rst),
    .sync_in (hsync),
    .fall    (hs_fall)
  );

  sync_edge_det u_vs_edge (
    .clk25   (clk25),
    .rst     (rst),
    .sync_in (vsync),
    .fall    (vs_fall)
  );

  // Pixel counter and pending-vsync flag; a vsync edge in the same cycle as
  // an hsync edge is seen by that hsync edge and then cleared.
  always_comb begin
    vpend_eff = vpend_q | vs_fall;
    line_end  = (hcount_q == H_LAST);
    if (hs_fall)                hcount_d = '0;
    else if (hcount_q == CNT_MAX) hcount_d = CNT_MAX;
    else                        hcount_d = hcount_q + 10'd1;
    vpend_d = hs_fall ? 1'b0 : vpend_eff;
  end

  // Lock FSM next state, line counter, frame_start and error detection.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d       = state_q;
    vcount_d      = vcount_q;
    frame_start_d = 1'b0;
    err_d         = 1'b0;
    lock_err      = 1'b0;
    unique case (state_q)
      HUNT: begin
        if (hs_fall) state_d = HLINE;
      end
      HLINE: begin
        if (hs_fall && line_end) state_d = VWAIT;
      end
      VWAIT: begin
        if (hs_fall) begin
          if (vpend_eff) begin
            state_d       = LOCKED;
            vcount_d      = '0;
            frame_start_d = 1'b1;
          end else if (!line_end) begin
            state_d = HLINE;
          end
        end
      end
      LOCKED: begin
        lock_err = (hs_fall != line_end)
                 || (hs_fall &&  vpend_eff && (vcount_q != V_LAST))
                 || (hs_fall && !vpend_eff && (vcount_q == V_LAST));
        if (lock_err) begin
          state_d = HUNT;
          err_d   = 1'b1;
        end else if (hs_fall) begin
          vcount_d      = vpend_eff ? 10'd0 : vcount_q + 10'd1;
          frame_start_d = vpend_eff;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  // Visible-window decode from the current counters, presented one clock later.
  always_comb begin
    active_d = (state_q == LOCKED)
             && in_window(hcount_q, H_BEG, H_END)
             && in_window(vcount_q, V_BEG, V_END);
    xpos_d   = active_d ? hcount_q - H_OFF : 10'd0;
    ypos_d   = active_d ? vcount_q - V_OFF : 10'd0;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk25) begin
    if (rst) begin
      state_q       <= HUNT;
      hcount_q      <= '0;
      vcount_q      <= '0;
      vpend_q       <= 1'b0;
      active_q      <= 1'b0;
      xpos_q        <= '0;
      ypos_q        <= '0;
      frame_start_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      vpend_q       <= vpend_d;
      active_q      <= active_d;
      xpos_q        <= xpos_d;
      ypos_q        <= ypos_d;
      frame_start_q <= frame_start_d;
      err_q         <= err_d;
    end
  end

  assign locked      = (state_q == LOCKED);
  assign active      = active_q;
  assign xpos        = xpos_q;
  assign ypos        = ypos_q;
  assign frame_start = frame_start_q;
  assign err         = err_q;

`ifdef VGA_SYNC_DECODER_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Saturating count of lock errors; advances together with the err pulse.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  // Error counter register; only reset clears it.
  always_ff @(posedge clk25) begin
    if (rst) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a shrunken timing (16 clocks per
// line, 10 lines per frame) so several frames and hundreds of relocks fit in
// a short run. A small sync generator drives hsync/vsync like vga_display.
module tb_vga_sync_decoder;

  localparam int HT = 16;
  localparam int HS = 4;
  localparam int HV = 8;
  localparam int VT = 10;
  localparam int VS = 2;
  localparam int VV = 6;

  logic       clk25 = 1'b0;
  logic       rst   = 1'b1;
  logic       hsync = 1'b1;
  logic       vsync = 1'b1;
  logic [9:0] xpos, ypos;
  logic       active, locked, frame_start, err;
`ifdef VGA_SYNC_DECODER_ERRCNT_EN
  logic [7:0] err_count;
`endif

  vga_sync_decoder #(
    .H_TOTAL   (HT),
    .H_START   (HS),
    .H_VISIBLE (HV),
    .V_TOTAL   (VT),
    .V_START   (VS),
    .V_VISIBLE (VV)
  ) dut (
    .clk25       (clk25),
    .rst         (rst),
    .hsync       (hsync),
    .vsync       (vsync),
    .xpos        (xpos),
    .ypos        (ypos),
    .active      (active),
    .locked      (locked),
    .frame_start (frame_start),
    .err         (err)
`ifdef VGA_SYNC_DECODER_ERRCNT_EN
    ,
    .err_count   (err_count)
`endif
  );

  always #5 clk25 = ~clk25;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   line_idx = 0;
  int   n_err    = 0;
  int   n_fs     = 0;
  int   n_active = 0;
  int   last_fs  = -1;
  int   gap_min  = 1 << 30;
  int   gap_max  = 0;
  int   first_x  = -1;
  int   first_y  = -1;
  int   last_x   = -1;
  int   last_y   = -1;
  int   want_first   = 0;
  int   err_wide     = 0;
  int   err_locked   = 0;
  int   idle_xy_bad  = 0;
  int   last_err_cyc = -1;
  logic prev_err     = 1'b0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // One clock: apply inputs, wait for the edge, sample outputs 1 time unit later.
  task automatic step(input logic hs, input logic vs);
    hsync = hs;
    vsync = vs;
    @(posedge clk25);
    #1;
    cyc++;
    if (err) begin
      n_err++;
      last_err_cyc = cyc;
      if (prev_err) err_wide++;
      if (locked)   err_locked++;
    end
    prev_err = err;
    if (frame_start) begin
      if (last_fs >= 0) begin
        if (cyc - last_fs < gap_min) gap_min = cyc - last_fs;
        if (cyc - last_fs > gap_max) gap_max = cyc - last_fs;
      end
      last_fs    = cyc;
      n_fs++;
      want_first = 1;
    end
    if (active) begin
      n_active++;
      if (want_first != 0) begin
        first_x    = int'(xpos);
        first_y    = int'(ypos);
        want_first = 0;
      end
      last_x = int'(xpos);
      last_y = int'(ypos);
    end else if ((xpos != 10'd0) || (ypos != 10'd0)) begin
      idle_xy_bad++;
    end
  endtask

  // One line of len clocks: hsync low for the first two clocks, vsync low all line if vlow.
  task automatic drive_line(input int len, input logic vlow);
    for (int c = 0; c < len; c++) step((c < 2) ? 1'b0 : 1'b1, ~vlow);
  endtask

  // n standard lines continuing the frame from line_idx; vsync is low on line 0.
  task automatic gen_lines(input int n);
    for (int l = 0; l < n; l++) begin
      drive_line(HT, line_idx == 0);
      line_idx = (line_idx + 1) % VT;
    end
  endtask

  task automatic clear_frame_stats();
    n_fs     = 0;
    n_active = 0;
    last_fs  = -1;
    gap_min  = 1 << 30;
    gap_max  = 0;
  endtask

  int err_base;
  int hold_start;

  initial begin
    // Reset with idle sync lines.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    chk("rst_locked", int'(locked), 0);
    chk("rst_active", int'(active), 0);
    chk("rst_xpos", int'(xpos), 0);
    chk("rst_ypos", int'(ypos), 0);
    chk("rst_frame_start", int'(frame_start), 0);
    chk("rst_err", int'(err), 0);
`ifdef VGA_SYNC_DECODER_ERRCNT_EN
    chk("rst_err_count", int'(err_count), 0);
`endif
    rst = 1'b0;

    // Join mid-frame: lines 5..9 walk HUNT -> HLINE -> VWAIT without locking.
    clear_frame_stats();
    line_idx = 5;
    gen_lines(5);
    chk("pre_vsync_locked", int'(locked), 0);

    // First vsync edge (coincident with hsync) locks and starts a frame.
    step(1'b0, 1'b0);
    chk("lock_on_vsync", int'(locked), 1);
    chk("lock_frame_start", int'(frame_start), 1);
    step(1'b0, 1'b0);
    for (int c = 2; c < HT; c++) step(1'b1, 1'b0);
    line_idx = 1;
    gen_lines(VT * 3 - 1);
    chk("frames_fs_count", n_fs, 3);
    chk("frames_fs_gap_min", gap_min, HT * VT);
    chk("frames_fs_gap_max", gap_max, HT * VT);
    chk("frames_active_cycles", n_active, 3 * HV * VV);
    chk("first_active_x", first_x, 0);
    chk("first_active_y", first_y, 0);
    chk("last_active_x", last_x, HV - 1);
    chk("last_active_y", last_y, VV - 1);
    chk("frames_still_locked", int'(locked), 1);
    chk("frames_no_err", n_err, 0);

    // Shortened line: one error, immediate unlock, relock at next vsync.
    err_base = n_err;
    gen_lines(3);
    drive_line(HT - 1, 1'b0);
    line_idx = 4;
    gen_lines(VT - 4);
    chk("short_line_err_once", n_err - err_base, 1);
    chk("short_line_unlocked", int'(locked), 0);
    gen_lines(1);
    chk("short_line_relock", int'(locked), 1);

    // hsync stuck high while locked: error on the expected edge cycle, then hunt.
    err_base   = n_err;
    clear_frame_stats();
    hold_start = cyc;
    for (int i = 0; i < 1000; i++) step(1'b1, 1'b1);
    chk("stuck_err_once", n_err - err_base, 1);
    chk("stuck_err_at_line_end", last_err_cyc - hold_start, 1);
    chk("stuck_no_active", n_active, 0);
    chk("stuck_unlocked", int'(locked), 0);
`ifdef VGA_SYNC_DECODER_ERRCNT_EN
    chk("err_count_two", int'(err_count), 2);
`endif

    // Relock, then pulse reset mid-frame inside the visible area.
    line_idx = 5;
    gen_lines(8);
    drive_line(6, 1'b0);
    chk("pre_rst_active", int'(active), 1);
    err_base = n_err;
    rst = 1'b1;
    step(1'b1, 1'b1);
    rst = 1'b0;
    chk("midrst_locked", int'(locked), 0);
    chk("midrst_active", int'(active), 0);
    chk("midrst_xpos", int'(xpos), 0);
    chk("midrst_ypos", int'(ypos), 0);
    chk("midrst_err", int'(err), 0);
`ifdef VGA_SYNC_DECODER_ERRCNT_EN
    chk("midrst_err_count", int'(err_count), 0);
`endif
    for (int c = 7; c < HT; c++) step(1'b1, 1'b1);
    line_idx = 4;
    gen_lines(VT - 4);
    chk("post_rst_hunting", int'(locked), 0);
    gen_lines(1);
    chk("post_rst_relock", int'(locked), 1);
    chk("post_rst_no_err", n_err - err_base, 0);

    // Repeated line-length errors, each followed by a minimal relock.
    err_base = n_err;
    for (int k = 0; k < 300; k++) begin
      drive_line(HT - 1, 1'b0);
      drive_line(HT, 1'b0);
      drive_line(HT, 1'b0);
      drive_line(HT, 1'b0);
      drive_line(HT, 1'b1);
      if (k == 9) begin
        chk("inject_10_errs", n_err - err_base, 10);
`ifdef VGA_SYNC_DECODER_ERRCNT_EN
        chk("err_count_10", int'(err_count), 10);
`endif
      end
    end
    chk("inject_300_errs", n_err - err_base, 300);
    chk("inject_relocked", int'(locked), 1);
`ifdef VGA_SYNC_DECODER_ERRCNT_EN
    chk("err_count_sat", int'(err_count), 255);
`endif

    // Missing vsync at the last line of a frame is an error.
    err_base = n_err;
    for (int l = 0; l < VT; l++) drive_line(HT, 1'b0);
    chk("missing_vsync_err", n_err - err_base, 1);
    chk("missing_vsync_unlocked", int'(locked), 0);
`ifdef VGA_SYNC_DECODER_ERRCNT_EN
    chk("err_count_held", int'(err_count), 255);
`endif

    // Whole-run invariants.
    chk("err_single_cycle", err_wide, 0);
    chk("err_clears_lock", err_locked, 0);
    chk("idle_xy_zero", idle_xy_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
